rat_intr_ctrl: RTL and testbench

Interrupt controller at the device end of the MCU interrupt handshake. It synchronizes and edge-detects external interrupt sources, applies an I/O-mapped mask, and holds the interrupt-enable flag driven by I_SET/I_CLR. It raises INT_R_MCU and retires the request on the MCU acknowledge; FLG_SHAD_LD is the acknowledge, because it is asserted only in the interrupt state. It exposes status on the IN-port mux.

---
 rtl/rat_intr_pkg.sv | 21 ++
 rtl/rat_intr_ctrl_sync_edge.sv | 28 ++
 rtl/rat_intr_ctrl.sv | 120 ++++++++++++
 tb/tb_rat_intr_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/rat_intr_pkg.sv
// Shared types and constants for the RAT interrupt controller.
package rat_intr_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SERVICE} INTR_STATES;

  localparam logic [7:0] MASK_PORT_ID_DEF = 8'h40;
  localparam logic [7:0] STAT_PORT_ID_DEF = 8'h41;

  // INT_STATUS layout: {OVF, IE, INT_ID[1:0], pending[3:0]}
  localparam int STAT_OVF_BIT  = 7;
  localparam int STAT_IE_BIT   = 6;
  localparam int STAT_ID_LSB   = 4;
  localparam int STAT_PEND_LSB = 0;

  function automatic logic [1:0] lowest_idx(input logic [3:0] v);
    lowest_idx = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (v[i]) lowest_idx = 2'(i);
  endfunction

endpackage

// File: rtl/rat_intr_ctrl_sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
module rat_sync_edge #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [W-1:0] din,
  output logic [W-1:0] rise
);

  logic [W-1:0] s1, s2, s2_d;

  // rise is high for one cycle, three clocks after din goes high
  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1   <= '0;
      s2   <= '0;
      s2_d <= '0;
      rise <= '0;
    end else begin
      s1   <= din;
      s2   <= s1;
      s2_d <= s2;
      rise <= s2 & ~s2_d;
    end
  end

endmodule

// File: rtl/rat_intr_ctrl.sv
// Device-side interrupt controller for the RAT MCU: sync/edge, mask, IE, request FSM.
// Optional sticky overflow flag enabled by defining RAT_INTR_OVF_EN.
module rat_intr_ctrl
  import rat_intr_pkg::*;
#(
  parameter int         NUM_SRC      = 4,
  parameter logic [7:0] MASK_PORT_ID = MASK_PORT_ID_DEF,
  parameter logic [7:0] STAT_PORT_ID = STAT_PORT_ID_DEF
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_SRC-1:0] SRC_IN,
  input  logic               I_SET,
  input  logic               I_CLR,
  input  logic               INT_ACK,
  input  logic               IO_STRB,
  input  logic [7:0]         PORT_ID,
  input  logic [7:0]         OUT_PORT,
  output logic               INT_R_MCU,
  output logic [1:0]         INT_ID,
  output logic               IE,
  output logic [7:0]         INT_STATUS
);

  INTR_STATES         state, state_nxt;
  logic [NUM_SRC-1:0] edge_v, mask, pending, mask_eff, set_vec, clr_vec;
  logic [3:0]         pend4;
  logic [1:0]         id_nxt;
  logic               ack, mask_wr, stat_wr, ovf;
  logic               out_port_unused;

  rat_sync_edge #(.W(NUM_SRC)) u_sync_edge (
    .CLK   (CLK),
    .RESET (RESET),
    .din   (SRC_IN),
    .rise  (edge_v)
  );

  assign mask_wr         = IO_STRB && (PORT_ID == MASK_PORT_ID);
  assign stat_wr         = IO_STRB && (PORT_ID == STAT_PORT_ID);
  assign out_port_unused = ^OUT_PORT;

  // An edge coincident with a mask write is gated by the new mask
  assign mask_eff = mask_wr ? OUT_PORT[NUM_SRC-1:0] : mask;
  assign set_vec  = edge_v & mask_eff;
  assign clr_vec  = ack ? (NUM_SRC'(1) << INT_ID) : '0;

  always_comb begin
    pend4                  = '0;
    pend4[NUM_SRC-1:0]     = pending;
  end

  always_comb begin
    state_nxt = state;
    id_nxt    = INT_ID;
    ack       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (IE && |pending) begin
          state_nxt = ST_REQ;
          id_nxt    = lowest_idx(pend4);
        end
      end
      ST_REQ: begin
        // Ack beats a coincident I_CLR; a bare I_CLR withdraws the request
        if (INT_ACK) begin
          ack       = 1'b1;
          state_nxt = ST_SERVICE;
        end else if (!IE || I_CLR) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (I_SET || I_CLR) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      INT_R_MCU <= 1'b0;
      INT_ID    <= 2'd0;
      IE        <= 1'b0;
      mask      <= '1;
      pending   <= '0;
    end else begin
      state     <= state_nxt;
      INT_R_MCU <= (state_nxt == ST_REQ);
      INT_ID    <= id_nxt;
      if (ack || I_CLR)  IE <= 1'b0;
      else if (I_SET)    IE <= 1'b1;
      if (mask_wr)       mask <= OUT_PORT[NUM_SRC-1:0];
      // Set wins over clear so an event landing on the ack cycle survives
      pending   <= ((pending & ~clr_vec) & mask_eff) | set_vec;
    end
  end

`ifdef RAT_INTR_OVF_EN
  always_ff @(posedge CLK) begin
    if (RESET)                                  ovf <= 1'b0;
    else if (|(set_vec & pending & ~clr_vec))   ovf <= 1'b1;
    else if (stat_wr)                           ovf <= 1'b0;
  end
`else
  logic stat_wr_unused;
  assign stat_wr_unused = stat_wr;
  assign ovf            = 1'b0;
`endif

  always_comb begin
    INT_STATUS                               = '0;
    INT_STATUS[STAT_OVF_BIT]                 = ovf;
    INT_STATUS[STAT_IE_BIT]                  = IE;
    INT_STATUS[STAT_ID_LSB +: 2]             = INT_ID;
    INT_STATUS[STAT_PEND_LSB +: 4]           = pend4;
  end

endmodule

// File: tb/tb_rat_intr_ctrl.sv
// Scoreboard bench for rat_intr_ctrl: directed stimulus, timed status and request queues.
module tb_rat_intr_ctrl;

  logic       CLK = 1'b0, RESET = 1'b1;
  logic [3:0] SRC_IN = '0;
  logic       I_SET = 0, I_CLR = 0, INT_ACK = 0, IO_STRB = 0;
  logic [7:0] PORT_ID = '0, OUT_PORT = '0;
  logic       INT_R_MCU, IE;
  logic [1:0] INT_ID;
  logic [7:0] INT_STATUS;

  rat_intr_ctrl #(.NUM_SRC(4)) dut (
    .CLK(CLK), .RESET(RESET), .SRC_IN(SRC_IN), .I_SET(I_SET), .I_CLR(I_CLR),
    .INT_ACK(INT_ACK), .IO_STRB(IO_STRB), .PORT_ID(PORT_ID), .OUT_PORT(OUT_PORT),
    .INT_R_MCU(INT_R_MCU), .INT_ID(INT_ID), .IE(IE), .INT_STATUS(INT_STATUS)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct { int cyc; string nm; logic [7:0] st; logic rq; } st_t;
  typedef struct { int cyc; logic [1:0] id; } rq_t;
  st_t st_q[$];
  rq_t rq_q[$];
  int  total = 0, bad = 0;

`ifdef RAT_INTR_OVF_EN
  localparam logic [7:0] OVF_EXP = 8'h91;
`else
  localparam logic [7:0] OVF_EXP = 8'h11;
`endif

  task automatic expect_st(input int c, input string nm, input logic [7:0] s, input logic rq);
    st_t e;
    int  k;
    e.cyc = c; e.nm = nm; e.st = s; e.rq = rq;
    k = st_q.size();
    while (k > 0 && st_q[k-1].cyc > c) k--;
    st_q.insert(k, e);
  endtask

  task automatic expect_req(input int c, input logic [1:0] id);
    rq_t e;
    e.cyc = c; e.id = id;
    rq_q.push_back(e);
  endtask

  task automatic go(input int c);
    while (cyc < c) begin
      @(posedge CLK); #1;
    end
  endtask

  // Monitor: request events and timed status snapshots, sampled mid-cycle
  logic req_prev = 1'b0;
  st_t  se;
  rq_t  re;
  always @(negedge CLK) begin
    if (INT_R_MCU && !req_prev) begin
      total++;
      if (rq_q.size() == 0) begin
        bad++;
        $display("FAIL req_unexpected cyc=%0d id=%0d", cyc, INT_ID);
      end else begin
        re = rq_q.pop_front();
        if (re.cyc != cyc || re.id != INT_ID) begin
          bad++;
          $display("FAIL req_rise cyc=%0d id=%0d expected cyc=%0d id=%0d", cyc, INT_ID, re.cyc, re.id);
        end
      end
    end
    req_prev = INT_R_MCU;
    while (st_q.size() > 0 && st_q[0].cyc <= cyc) begin
      se = st_q.pop_front();
      total++;
      if (se.cyc < cyc) begin
        bad++;
        $display("FAIL %s missed cyc=%0d", se.nm, se.cyc);
      end else if (INT_STATUS !== se.st || INT_R_MCU !== se.rq) begin
        bad++;
        $display("FAIL %s cyc=%0d status=%h req=%b expected status=%h req=%b",
                 se.nm, cyc, INT_STATUS, INT_R_MCU, se.st, se.rq);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  int r, n, m, q, u;
  initial begin
    repeat (3) @(posedge CLK);
    #1;
    RESET = 0; r = cyc;
    expect_st(r, "reset", 8'h00, 0);

    // Basic request on source 2, then ack
    I_SET = 1;
    go(r + 1); I_SET = 0; SRC_IN = 4'b0100; n = cyc;
    expect_st(n, "ie_set", 8'h40, 0);
    expect_st(n + 4, "a_pend", 8'h44, 0);
    expect_req(n + 5, 2'd2);
    expect_st(n + 5, "a_req", 8'h64, 1);
    go(n + 5); INT_ACK = 1;
    expect_st(n + 6, "a_ack", 8'h20, 0);
    go(n + 6); INT_ACK = 0;

    // Priority: sources 3 and 1 together
    m = cyc; I_SET = 1; SRC_IN = 4'b1010;
    go(m + 1); I_SET = 0;
    expect_st(m + 4, "b_pend", 8'h6A, 0);
    expect_req(m + 5, 2'd1);
    expect_st(m + 5, "b_req1", 8'h5A, 1);
    go(m + 5); INT_ACK = 1;
    expect_st(m + 6, "b_ack1", 8'h18, 0);
    go(m + 6); INT_ACK = 0; I_SET = 1;
    expect_st(m + 7, "b_reti", 8'h58, 0);
    expect_req(m + 8, 2'd3);
    expect_st(m + 8, "b_req3", 8'h78, 1);
    go(m + 7); I_SET = 0;
    go(m + 8); INT_ACK = 1;
    expect_st(m + 9, "b_ack3", 8'h30, 0);
    go(m + 9); INT_ACK = 0; I_CLR = 1; SRC_IN = '0;
    go(m + 10); I_CLR = 0;

    // Withdrawal, re-raise, ack/edge collision, reset mid-request
    q = cyc; SRC_IN = 4'b0001; I_SET = 1;
    go(q + 1); I_SET = 0;
    expect_req(q + 5, 2'd0);
    expect_st(q + 5, "d_req", 8'h41, 1);
    go(q + 2); SRC_IN = '0;
    go(q + 5); I_CLR = 1; SRC_IN = 4'b0001;
    expect_st(q + 6, "d_withdraw", 8'h01, 0);
    go(q + 6); I_CLR = 0; I_SET = 1;
    expect_st(q + 7, "d_reset_ie", 8'h41, 0);
    expect_req(q + 8, 2'd0);
    expect_st(q + 8, "d_rereq", 8'h41, 1);
    go(q + 7); I_SET = 0;
    go(q + 8); INT_ACK = 1;
    expect_st(q + 9, "e_collision", 8'h01, 0);
    go(q + 9); INT_ACK = 0; I_SET = 1;
    expect_req(q + 11, 2'd0);
    expect_st(q + 11, "f_req", 8'h41, 1);
    go(q + 10); I_SET = 0;
    go(q + 11); RESET = 1;
    expect_st(q + 12, "f_reset", 8'h00, 0);
    go(q + 12); RESET = 0;
    expect_st(q + 16, "f_mask_rst", 8'h01, 0);
    go(q + 16);

    // Masking
    u = cyc; SRC_IN = 4'b0010;
    expect_st(u + 4, "c_pend", 8'h03, 0);
    go(u + 4); IO_STRB = 1; PORT_ID = 8'h40; OUT_PORT = 8'h02;
    expect_st(u + 5, "c_maskwr", 8'h02, 0);
    go(u + 5); IO_STRB = 0; PORT_ID = 8'h00; SRC_IN = 4'b0011;
    expect_st(u + 9, "c_masked_edge", 8'h02, 0);
    go(u + 9); I_SET = 1;
    expect_st(u + 10, "c_status42", 8'h42, 0);
    expect_req(u + 11, 2'd1);
    expect_st(u + 11, "c_req", 8'h52, 1);
    go(u + 10); I_SET = 0;
    go(u + 11); INT_ACK = 1;
    expect_st(u + 12, "c_ack", 8'h10, 0);
    go(u + 12); INT_ACK = 0; I_CLR = 1;
    go(u + 13); I_CLR = 0; IO_STRB = 1; PORT_ID = 8'h40; OUT_PORT = 8'h0F; SRC_IN = 4'b0010;

    // Overflow: second edge on an already-pending source
    go(u + 14); IO_STRB = 0; PORT_ID = 8'h00; OUT_PORT = 8'h00;
    go(u + 15); SRC_IN = 4'b0011;
    expect_st(u + 19, "g_pend", 8'h11, 0);
    go(u + 19); SRC_IN = 4'b0010;
    go(u + 21); SRC_IN = 4'b0011;
    expect_st(u + 25, "g_ovf", OVF_EXP, 0);
    go(u + 25); IO_STRB = 1; PORT_ID = 8'h41;
    expect_st(u + 26, "g_ovf_clr", 8'h11, 0);
    go(u + 26); IO_STRB = 0; PORT_ID = 8'h00;

    go(u + 30);
    if (st_q.size() != 0 || rq_q.size() != 0) begin
      total++; bad++;
      $display("FAIL leftover status=%0d req=%0d expected 0 0", st_q.size(), rq_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
